// File: rtl/instr_fetch.sv
// Fetch stage: loadable instruction memory plus PC, issuing one word per
// valid/ready handshake to the decoder, with redirect and halt-word support.
module instr_fetch #(
  parameter int unsigned       ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              run,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                valid_q;
  logic [DATA_W-1:0]   instr_q;
  logic [ADDR_W-1:0]   pc_out_q;
  logic                halted_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [DATA_W-1:0]   fetch_word_c;
  logic                slot_free_c;
  logic [ADDR_W-1:0]   pc_inc_c;

  // Combinational read of the word at the current PC and slot availability.
  always_comb begin
    fetch_word_c = mem_q[pc_q];
    slot_free_c  = !valid_q || instr_ready;
    pc_inc_c     = pc_q + ADDR_W'(1);
  end

  // Instruction memory write port; loads are only accepted while not running.
  always_ff @(posedge clk) begin
    if (load_en && (state_q != ST_RUN)) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Fetch FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (redirect_en) begin
            // Redirect flushes any pending word and skips this cycle's fetch.
            pc_q    <= redirect_pc;
            valid_q <= 1'b0;
          end else if (slot_free_c) begin
            if (fetch_word_c == HALT_WORD) begin
              // Slot is free, so any pending word is consumed this edge.
              valid_q  <= 1'b0;
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end else begin
              instr_q  <= fetch_word_c;
              pc_out_q <= pc_q;
              valid_q  <= 1'b1;
              pc_q     <= pc_inc_c;
            end
          end
        end
        ST_HALT: begin
          if (instr_ready) begin
            valid_q <= 1'b0;
          end
          if (run) begin
            pc_q     <= RESET_PC;
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-order model predicts the issued
// (pc, word) stream; a negedge monitor pops and compares on every transfer.
module tb_instr_fetch;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              run;
  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_ready;
  logic              instr_valid;
  logic [31:0]       instr_out;
  logic [ADDR_W-1:0] pc_out;
  logic              halted;

  int total = 0;
  int bad   = 0;

  logic [31:0]          mdl [DEPTH];
  logic [ADDR_W+31:0]   exp_q [$];

  logic              hold_v = 1'b0;
  logic [31:0]       hold_instr;
  logic [ADDR_W-1:0] hold_pc;

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC('0), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .run(run), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  // Write one word; the model follows only when the write should be honoured.
  task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d, input bit honoured);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
    if (honoured) mdl[a] = d;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // Expected stream: consecutive words from start (wrapping) up to the halt word.
  task automatic push_prog(input logic [ADDR_W-1:0] start);
    logic [ADDR_W-1:0] p;
    p = start;
    for (int n = 0; n < DEPTH; n++) begin
      if (mdl[p] == HALT) break;
      exp_q.push_back({p, mdl[p]});
      p = p + ADDR_W'(1);
    end
  endtask

  // Run until halted and drained, optionally with random backpressure.
  task automatic wait_halt(input string name, input bit rnd_ready);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (halted && !instr_valid && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      if (rnd_ready) instr_ready = 1'($urandom_range(0, 1));
      tick();
    end
    instr_ready = 1'b1;
    chk({name, "_halted_drained"}, 32'(done), 32'd1);
  endtask

  // Monitor: transfer check, halt-word leak check, stability under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && instr_valid) begin
        total++;
        if (instr_out !== hold_instr || pc_out !== hold_pc) begin
          bad++;
          $display("FAIL stable: got pc=%0d w=%h expected pc=%0d w=%h",
                   pc_out, instr_out, hold_pc, hold_instr);
        end
      end
      if (instr_valid) begin
        total++;
        if (instr_out === HALT) begin
          bad++;
          $display("FAIL halt_leak: got %h issued, expected never", instr_out);
        end
      end
      if (instr_valid && instr_ready && !redirect_en) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL xfer_unexpected: got pc=%0d w=%h expected none", pc_out, instr_out);
        end else begin
          logic [ADDR_W+31:0] e;
          e = exp_q.pop_front();
          if ({pc_out, instr_out} !== e) begin
            bad++;
            $display("FAIL xfer: got pc=%0d w=%h expected pc=%0d w=%h",
                     pc_out, instr_out, e[ADDR_W+31:32], e[31:0]);
          end
        end
      end
      hold_v     = instr_valid && !instr_ready;
      hold_instr = instr_out;
      hold_pc    = pc_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; run = 1'b0;
    redirect_en = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    #2;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc_out", 32'(pc_out), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    tick();
    rst = 1'b0;

    // Fill memory with non-halt words so every location is defined.
    for (int i = 0; i < DEPTH; i++) load(ADDR_W'(i), rnd_word(), 1'b1);

    // T1: basic program, halt word loaded in the same cycle as run.
    load(6'd0, 32'h0A8C_0000, 1'b1);
    load(6'd1, 32'h1234_5678, 1'b1);
    instr_ready = 1'b1;
    load_en = 1'b1; load_addr = 6'd2; load_data = HALT; run = 1'b1;
    tick();
    load_en = 1'b0; run = 1'b0; mdl[2] = HALT;
    push_prog(6'd0);
    chk("t1_lat1_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("t1_lat2_valid", 32'(instr_valid), 32'd1);
    chk("t1_first_word", instr_out, 32'h0A8C_0000);
    chk("t1_first_pc", 32'(pc_out), 32'd0);
    wait_halt("t1", 1'b0);
    chk("t1_halted", 32'(halted), 32'd1);

    // T2: restart from HALT with backpressure on the first word.
    instr_ready = 1'b0;
    pulse_run();
    push_prog(6'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(instr_valid), 32'd1);
      chk("t2_hold_word", instr_out, 32'h0A8C_0000);
      chk("t2_hold_pc", 32'(pc_out), 32'd0);
      tick();
    end
    chk("t2_not_halted", 32'(halted), 32'd0);
    instr_ready = 1'b1;
    tick();
    chk("t2_next_word", instr_out, 32'h1234_5678);
    chk("t2_next_pc", 32'(pc_out), 32'd1);
    wait_halt("t2", 1'b0);

    // T3: redirect while a word is pending flushes it.
    load(6'd2, rnd_word(), 1'b1);
    load(6'd22, HALT, 1'b1);
    instr_ready = 1'b0;
    pulse_run();
    for (int i = 0; i < 3; i++) exp_q.push_back({ADDR_W'(i), mdl[i]});
    tick();
    instr_ready = 1'b1;
    repeat (3) tick();
    instr_ready = 1'b0;
    chk("t3_pending_pc", 32'(pc_out), 32'd3);
    chk("t3_pending_valid", 32'(instr_valid), 32'd1);
    redirect_en = 1'b1; redirect_pc = 6'd20;
    tick();
    redirect_en = 1'b0;
    chk("t3_flushed", 32'(instr_valid), 32'd0);
    push_prog(6'd20);
    tick();
    chk("t3_target_pc", 32'(pc_out), 32'd20);
    chk("t3_target_word", instr_out, mdl[20]);
    wait_halt("t3", 1'b1);

    // T4: PC wraps from the top of memory to zero.
    load(6'd63, 32'h0000_0001, 1'b1);
    load(6'd0, 32'h0000_0002, 1'b1);
    load(6'd1, HALT, 1'b1);
    instr_ready = 1'b0;
    pulse_run();
    redirect_en = 1'b1; redirect_pc = 6'd63;
    tick();
    redirect_en = 1'b0;
    push_prog(6'd63);
    wait_halt("t4", 1'b1);

    // T5: asynchronous reset while a word is pending.
    instr_ready = 1'b0;
    pulse_run();
    tick();
    chk("t5_pending_valid", 32'(instr_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(instr_valid), 32'd0);
    chk("t5_rst_instr", instr_out, 32'd0);
    chk("t5_rst_pc_out", 32'(pc_out), 32'd0);
    chk("t5_rst_halted", 32'(halted), 32'd0);
    #1 rst = 1'b0;
    tick();
    push_prog(6'd0);
    pulse_run();
    wait_halt("t5", 1'b1);

    // T6: loads and run pulses during RUN are ignored; HALT restart at zero.
    load(6'd0, 32'h0A8C_0000, 1'b1);
    load(6'd1, 32'h1234_5678, 1'b1);
    load(6'd2, HALT, 1'b1);
    instr_ready = 1'b0;
    pulse_run();
    push_prog(6'd0);
    run = 1'b1;
    load(6'd1, 32'hDEAD_BEEF, 1'b0);
    run = 1'b0;
    wait_halt("t6a", 1'b1);
    pulse_run();
    push_prog(6'd0);
    wait_halt("t6b", 1'b1);

    // T7: random programs under random backpressure.
    for (int it = 0; it < 4; it++) begin
      int h;
      h = $urandom_range(3, 30);
      for (int i = 0; i < h; i++) load(ADDR_W'(i), rnd_word(), 1'b1);
      load(ADDR_W'(h), HALT, 1'b1);
      pulse_run();
      push_prog(6'd0);
      wait_halt("t7", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
